// File: rtl/image_loader_if.sv
// Pixel stream, classifier read port and classifier control bundle for image_loader.
interface image_loader_if;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        pix_ready;
  logic [15:0] addrA;
  logic [31:0] dataA;
  logic        nn_done;
  logic        nn_reset;
  logic [7:0]  frame_count;

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  addrA,
    input  nn_done,
    output pix_ready,
    output dataA,
    output nn_reset,
    output frame_count
  );

  modport master (
    output pix_valid,
    output pix_data,
    output addrA,
    output nn_done,
    input  pix_ready,
    input  dataA,
    input  nn_reset,
    input  frame_count
  );
endinterface

// File: rtl/image_loader.sv
// Binarising frame loader feeding a classifier; IMAGE_LOADER_DOUBLE_BUF_EN selects
// ping-pong banks (fill next frame while classifying), otherwise a single bank.
module image_loader #(
  parameter int PIXELS = 784,
  parameter int THRESH = 128
) (
  input  logic          clk,
  input  logic          reset,
  image_loader_if.slave bus
);

`ifdef IMAGE_LOADER_DOUBLE_BUF_EN
  localparam int NBANKS = 2;
`else
  localparam int NBANKS = 1;
`endif
  localparam int AW    = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int DEPTH = NBANKS * PIXELS;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW-1:0] LAST_ADDR   = AW'(PIXELS - 1);
  localparam logic [IW-1:0] BANK_STRIDE = IW'(PIXELS);
  localparam logic [15:0]   ADDR_LIMIT  = 16'(PIXELS);
  localparam logic [7:0]    THRESH_B    = 8'(THRESH);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_WAIT = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          bank_q, bank_d;
  logic          pix_ready_q, pix_ready_d;
  logic          nn_reset_q, nn_reset_d;
  logic [7:0]    frame_count_q, frame_count_d;
  logic [31:0]   dataA_q, dataA_d;
`ifdef IMAGE_LOADER_DOUBLE_BUF_EN
  logic          pend_q, pend_d;
`endif

  logic          mem_q [DEPTH];

  logic          accept_s;
  logic          last_s;
  logic          pix_bit_s;
  logic          wr_bank_s;
  logic          rd_bank_s;
  logic          rd_hit_s;
  logic [IW-1:0] wr_idx_s;
  logic [IW-1:0] rd_idx_s;

  assign accept_s  = bus.pix_valid & pix_ready_q;
  assign last_s    = accept_s & (wr_cnt_q == LAST_ADDR);
  assign pix_bit_s = (bus.pix_data >= THRESH_B);
  assign rd_bank_s = bank_q;
`ifdef IMAGE_LOADER_DOUBLE_BUF_EN
  assign wr_bank_s = ~bank_q;
`else
  assign wr_bank_s = bank_q;
`endif

  // Bank-relative addresses into the shared pixel array and the read-path next value.
  always_comb begin
    wr_idx_s = (wr_bank_s ? BANK_STRIDE : {IW{1'b0}}) + IW'(wr_cnt_q);
    rd_hit_s = (bus.addrA < ADDR_LIMIT);
    if (rd_hit_s) begin
      rd_idx_s = (rd_bank_s ? BANK_STRIDE : {IW{1'b0}}) + IW'(bus.addrA[AW-1:0]);
      dataA_d  = {31'b0, mem_q[rd_idx_s]};
    end else begin
      rd_idx_s = {IW{1'b0}};
      dataA_d  = 32'b0;
    end
  end

  // Control FSM next state: frame fill, one-cycle handoff, classification.
  always_comb begin
    state_d       = state_q;
    bank_d        = bank_q;
    pix_ready_d   = pix_ready_q;
    nn_reset_d    = nn_reset_q;
    frame_count_d = frame_count_q;
`ifdef IMAGE_LOADER_DOUBLE_BUF_EN
    pend_d        = pend_q;
`endif
    if (last_s) begin
      wr_cnt_d = {AW{1'b0}};
    end else if (accept_s) begin
      wr_cnt_d = wr_cnt_q + AW'(1);
    end else begin
      wr_cnt_d = wr_cnt_q;
    end

    case (state_q)
      S_FILL: begin
        nn_reset_d = 1'b1;
        if (last_s) begin
          state_d     = S_WAIT;
          pix_ready_d = 1'b0;
        end else begin
          pix_ready_d = 1'b1;
        end
      end
      S_WAIT: begin
        state_d       = S_RUN;
        nn_reset_d    = 1'b0;
        frame_count_d = frame_count_q + 8'd1;
`ifdef IMAGE_LOADER_DOUBLE_BUF_EN
        bank_d        = ~bank_q;
        pend_d        = 1'b0;
        pix_ready_d   = 1'b1;
`else
        pix_ready_d   = 1'b0;
`endif
      end
      S_RUN: begin
`ifdef IMAGE_LOADER_DOUBLE_BUF_EN
        // A frame finished now or earlier goes straight to WAIT so nn_reset pulses once.
        if (bus.nn_done) begin
          nn_reset_d = 1'b1;
          if (pend_q || last_s) begin
            state_d     = S_WAIT;
            pix_ready_d = 1'b0;
            pend_d      = 1'b0;
          end else begin
            state_d     = S_FILL;
            pix_ready_d = 1'b1;
          end
        end else begin
          nn_reset_d = 1'b0;
          if (last_s) begin
            pend_d      = 1'b1;
            pix_ready_d = 1'b0;
          end else begin
            pix_ready_d = ~pend_q;
          end
        end
`else
        if (bus.nn_done) begin
          state_d     = S_FILL;
          nn_reset_d  = 1'b1;
          pix_ready_d = 1'b1;
        end else begin
          nn_reset_d  = 1'b0;
          pix_ready_d = 1'b0;
        end
`endif
      end
      default: begin
        state_d     = S_FILL;
        nn_reset_d  = 1'b1;
        pix_ready_d = 1'b0;
      end
    endcase
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_FILL;
      wr_cnt_q      <= {AW{1'b0}};
      bank_q        <= 1'b0;
      pix_ready_q   <= 1'b0;
      nn_reset_q    <= 1'b1;
      frame_count_q <= 8'd0;
`ifdef IMAGE_LOADER_DOUBLE_BUF_EN
      pend_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      wr_cnt_q      <= wr_cnt_d;
      bank_q        <= bank_d;
      pix_ready_q   <= pix_ready_d;
      nn_reset_q    <= nn_reset_d;
      frame_count_q <= frame_count_d;
`ifdef IMAGE_LOADER_DOUBLE_BUF_EN
      pend_q        <= pend_d;
`endif
    end
  end

  // Registered classifier read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataA_q <= 32'b0;
    end else begin
      dataA_q <= dataA_d;
    end
  end

  // Pixel storage write; contents survive reset.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      mem_q[wr_idx_s] <= pix_bit_s;
    end
  end

  assign bus.pix_ready   = pix_ready_q;
  assign bus.nn_reset    = nn_reset_q;
  assign bus.frame_count = frame_count_q;
  assign bus.dataA       = dataA_q;

endmodule

// File: tb/tb_image_loader.sv
// Directed self-checking bench for image_loader; covers both the default build and
// the IMAGE_LOADER_DOUBLE_BUF_EN build.
module tb_image_loader;
  localparam int PIXELS = 784;

  logic clk = 1'b0;
  logic reset;

  image_loader_if bus ();

  image_loader #(.PIXELS(PIXELS), .THRESH(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pix_val(input int fid, input int i);
    case (fid)
      0:       return 8'd200;
      1:       return (i == 0) ? 8'd127 : (i == 1) ? 8'd128 : 8'((i * 37 + 11) % 256);
      2:       return 8'((i * 53 + 7) % 256);
      3:       return 8'((i * 29 + 100) % 256);
      default: return 8'((i * 91 + 3) % 256);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    bus.nn_done = 1'b1;
    tick();
    bus.nn_done = 1'b0;
  endtask

  // Holds the pixel until accepted; optionally raises nn_done on the accepting cycle.
  task automatic send_pixel(input logic [7:0] d, input logic done);
    logic acc;
    acc = 1'b0;
    bus.pix_valid = 1'b1;
    bus.pix_data  = d;
    for (int t = 0; t < 64 && !acc; t++) begin
      acc         = bus.pix_ready;
      bus.nn_done = done & acc;
      tick();
      bus.nn_done = 1'b0;
    end
    if (!acc) check("pix_accept_timeout", {31'b0, bus.pix_ready}, 32'd1);
  endtask

  task automatic stream(input int fid, input int first, input int count, input logic done_last);
    for (int i = first; i < first + count; i++)
      send_pixel(pix_val(fid, i), done_last && (i == first + count - 1));
    bus.pix_valid = 1'b0;
  endtask

  task automatic read_one(input string tag, input int addr, input logic [31:0] exp);
    bus.addrA = 16'(addr);
    exp_q.push_back(exp);
    tick();
    check(tag, bus.dataA, exp_q.pop_front());
  endtask

  task automatic read_frame(input int fid, input string tag);
    for (int i = 0; i < PIXELS; i++)
      read_one(tag, i, {31'b0, (pix_val(fid, i) >= 8'd128)});
    read_one("dataA_oob_784", PIXELS, 32'd0);
    read_one("dataA_oob_ffff", 16'hFFFF, 32'd0);
  endtask

  task automatic expect_handoff(input string tag, input logic [7:0] fc);
    check({tag, "_nn_reset_wait"}, {31'b0, bus.nn_reset}, 32'd1);
    check({tag, "_ready_wait"}, {31'b0, bus.pix_ready}, 32'd0);
    tick();
    check({tag, "_nn_reset_run"}, {31'b0, bus.nn_reset}, 32'd0);
    check({tag, "_frame_count"}, {24'b0, bus.frame_count}, {24'b0, fc});
  endtask

  initial begin
    reset         = 1'b1;
    bus.pix_valid = 1'b0;
    bus.pix_data  = 8'd0;
    bus.addrA     = 16'd0;
    bus.nn_done   = 1'b0;
    #2;
    check("rst_pix_ready", {31'b0, bus.pix_ready}, 32'd0);
    check("rst_nn_reset", {31'b0, bus.nn_reset}, 32'd1);
    check("rst_dataA", bus.dataA, 32'd0);
    check("rst_frame_count", {24'b0, bus.frame_count}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("ready_before_edge", {31'b0, bus.pix_ready}, 32'd0);
    tick();
    check("ready_first_edge", {31'b0, bus.pix_ready}, 32'd1);

    // Frame A: all 200.
    stream(0, 0, PIXELS, 1'b0);
    expect_handoff("frameA", 8'd1);
    read_frame(0, "dataA_frameA");

`ifdef IMAGE_LOADER_DOUBLE_BUF_EN
    check("ready_run_dbuf", {31'b0, bus.pix_ready}, 32'd1);
    stream(1, 0, PIXELS, 1'b0);
    check("held_ready", {31'b0, bus.pix_ready}, 32'd0);
    repeat (3) tick();
    check("held_ready_later", {31'b0, bus.pix_ready}, 32'd0);
    check("held_nn_reset", {31'b0, bus.nn_reset}, 32'd0);
    check("held_frame_count", {24'b0, bus.frame_count}, 32'd1);
    read_one("held_read_bank", 5, 32'd1);
    pulse_done();
    expect_handoff("frameB", 8'd2);
    check("frameB_ready_run", {31'b0, bus.pix_ready}, 32'd1);
`else
    bus.pix_valid = 1'b1;
    repeat (3) tick();
    check("ready_run_sbuf", {31'b0, bus.pix_ready}, 32'd0);
    bus.pix_valid = 1'b0;
    pulse_done();
    check("done_nn_reset", {31'b0, bus.nn_reset}, 32'd1);
    check("done_ready", {31'b0, bus.pix_ready}, 32'd1);
    pulse_done();
    check("spurious_nn_reset", {31'b0, bus.nn_reset}, 32'd1);
    check("spurious_ready", {31'b0, bus.pix_ready}, 32'd1);
    check("spurious_frame_count", {24'b0, bus.frame_count}, 32'd1);
    stream(1, 0, PIXELS, 1'b0);
    expect_handoff("frameB", 8'd2);
`endif
    read_one("thresh_127", 0, 32'd0);
    read_one("thresh_128", 1, 32'd1);
    read_frame(1, "dataA_frameB");

    // Frame C: in the double-buffer build the last pixel coincides with nn_done.
`ifdef IMAGE_LOADER_DOUBLE_BUF_EN
    stream(2, 0, PIXELS, 1'b1);
`else
    pulse_done();
    stream(2, 0, PIXELS, 1'b0);
`endif
    expect_handoff("frameC", 8'd3);
    read_frame(2, "dataA_frameC");

    // Reset in the middle of a frame.
`ifndef IMAGE_LOADER_DOUBLE_BUF_EN
    pulse_done();
`endif
    bus.addrA = 16'd3;
    stream(3, 0, 400, 1'b0);
    check("dataA_pre_reset", bus.dataA, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_pix_ready", {31'b0, bus.pix_ready}, 32'd0);
    check("midrst_nn_reset", {31'b0, bus.nn_reset}, 32'd1);
    check("midrst_dataA", bus.dataA, 32'd0);
    check("midrst_frame_count", {24'b0, bus.frame_count}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("midrst_ready_rise", {31'b0, bus.pix_ready}, 32'd1);
    stream(4, 0, PIXELS - 1, 1'b0);
    check("partial_nn_reset", {31'b0, bus.nn_reset}, 32'd1);
    check("partial_ready", {31'b0, bus.pix_ready}, 32'd1);
    stream(4, PIXELS - 1, 1, 1'b0);
    expect_handoff("frameE", 8'd1);
    read_frame(4, "dataA_frameE");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/image_loader.md
IMAGE_LOADER -- requirements
Module: image_loader

Interface
REQ-001 Parameter PIXELS, default 784: pixels per frame, equal to the classifier input dimension.
REQ-002 Parameter THRESH, default 128: binarisation threshold; a pixel is stored as 1 when pix_data >= THRESH.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pix_valid  input  1  upstream pixel byte valid.
REQ-006 pix_data  input  8  greyscale pixel, raster order, pixel 0 first.
REQ-007 pix_ready  output  1  loader can accept a pixel this cycle.
REQ-008 addrA  input  16  classifier read address.
REQ-009 dataA  output  32  stored pixel in bit 0; bits 31:1 SHALL be 0.
REQ-010 nn_done  input  1  single-cycle pulse from the classifier when a result is valid.
REQ-011 nn_reset  output  1  classifier reset; low only while a frame is being classified.
REQ-012 frame_count  output  8  number of frames handed to the classifier, wraps 255->0.

Function
REQ-013 A pixel SHALL be accepted only on a cycle with pix_valid and pix_ready both high.
REQ-014 Each accepted pixel SHALL be written to write-bank address wr_cnt, and wr_cnt SHALL then increment.
REQ-015 The pixel accepted at wr_cnt = PIXELS-1 SHALL complete the frame; wr_cnt SHALL wrap to 0.
REQ-016 Read path: dataA SHALL reflect read-bank[addrA] exactly one cycle after addrA is presented (registered read).
REQ-017 For addrA >= PIXELS, dataA SHALL be 0.
REQ-018 Control FSM states: FILL, WAIT, RUN.
- FILL: pix_ready = 1 when the write bank is free. Frame complete -> WAIT.
- WAIT: pix_ready = 0, nn_reset = 1. Next cycle: swap banks -> RUN.
- RUN: nn_reset = 0; the classifier reads the read bank. nn_done -> FILL, with nn_reset = 1 on the following cycle.
REQ-019 With double buffering, pix_ready SHALL remain 1 during RUN while the write bank is still filling.
REQ-020 If the write frame completes during RUN, pix_ready SHALL drop and the loader SHALL hold that frame until nn_done, then swap and re-enter RUN via WAIT.
REQ-021 If nn_done and the final pixel occur in the same cycle, the RUN->WAIT->RUN handoff SHALL proceed.
- No pixel is lost.
- nn_reset SHALL be high for exactly one cycle between frames.
REQ-022 frame_count SHALL increment on each WAIT->RUN transition.
REQ-023 nn_done outside RUN SHALL be ignored.
REQ-024 Partial frames SHALL never be presented; nn_reset SHALL stay high until a full PIXELS-pixel frame exists.

Reset
REQ-025 On reset assertion, SHALL asynchronously set:
- state = FILL
- wr_cnt = 0, bank select = 0
- nn_reset = 1, pix_ready = 0
- dataA = 0, frame_count = 0
REQ-026 pix_ready SHALL rise on the first clock edge after reset deasserts.
REQ-027 Reset mid-frame SHALL discard the partial frame.
REQ-028 Pixel memory contents need not be cleared by reset.

Configuration
REQ-029 Macro IMAGE_LOADER_DOUBLE_BUF_EN.
- Defined: two PIXELS-deep 1-bit banks, ping-pong per REQ-018 to REQ-021.
- Undefined: a single bank, and pix_ready SHALL be 0 throughout WAIT and RUN, so filling and classification never overlap. All other behaviour is unchanged.

Verification
REQ-030 Reset, then stream 784 pixels, all 200 -> nn_reset falls 2 cycles after the last accept; reading addrA 0..783 returns dataA = 1 each one cycle later; frame_count = 1.
REQ-031 Pixels 127 and 128 at addresses 0 and 1 -> dataA = 0 and dataA = 1 respectively; addrA = 784 -> dataA = 0.
REQ-032 Double-buffer build: second frame streamed during RUN, no nn_done -> pix_ready drops after pixel 783; pulse nn_done -> one-cycle nn_reset high, second image read back, frame_count = 2.
REQ-033 Last pixel and nn_done in the same cycle -> no lost pixel, single-cycle nn_reset gap, frame_count increments once.
REQ-034 Assert reset after pixel 400 -> outputs at reset values immediately; a fresh 784-pixel frame is required before nn_reset falls.
REQ-035 Single-buffer build: pix_ready = 0 from WAIT until nn_done; a spurious nn_done in FILL has no effect.
